// File: rtl/mem_wr_burst.sv
// mem_wr_burst: gathers consecutive-address single-word writes into SDRAM write bursts.
module mem_wr_burst #(
    parameter int AW       = 25,
    parameter int DW       = 16,
    parameter int BURST    = 8,
    parameter int TIMEOUT  = 16,
    parameter int COL_BITS = 9
) (
    input  logic                   mem_clk,
    input  logic                   rst,
    input  logic                   in_wr_req,
    input  logic [AW-1:0]          in_wr_addr,
    input  logic [DW-1:0]          in_wr_data,
    output logic                   in_ack,
    output logic                   in_idle,
    output logic                   sd_wr_req,
    output logic [AW-1:0]          sd_wr_addr,
    output logic [$clog2(BURST):0] sd_wr_len,
    input  logic                   sd_ack,
    input  logic                   sd_data_next,
    output logic [DW-1:0]          sd_wr_data
);
    localparam int LW = $clog2(BURST);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [LW:0] FULL = (LW+1)'(BURST);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, REQ, XFER} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] buf_q [BURST];
    logic [LW:0]   count_q, count_d, count_acc;
    logic [AW-1:0] next_addr_q, next_addr_d, addr_acc;
    logic [AW-1:0] start_addr_q, start_addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ack_q, ack_d;
    logic          req_q, req_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [LW:0]   len_q, len_d;
    logic [DW-1:0] data_q, data_d;
    logic          mismatch, row_hold, acc, flush, to_xfer, step, last;

    // ack_q gates both accept and mismatch so a request held through its ack cycle is ignored
    always_comb begin
        mismatch  = state_q == COLLECT && in_wr_req && !ack_q && in_wr_addr != next_addr_q;
        row_hold  = state_q == COLLECT && next_addr_q[COL_BITS-1:0] == '0;
        acc       = in_wr_req && !ack_q && count_q < FULL &&
                    (state_q == IDLE || (state_q == COLLECT && !mismatch && !row_hold));
        count_acc = acc ? count_q + (LW+1)'(1) : count_q;
        addr_acc  = acc ? in_wr_addr + AW'(1) : next_addr_q;
        flush     = state_q == COLLECT && (count_acc == FULL || addr_acc[COL_BITS-1:0] == '0 ||
                    mismatch || (!acc && tmo_q == TMO_LAST));
        to_xfer   = state_q == REQ && sd_ack;
        step      = state_q == XFER && sd_data_next;
        last      = step && {1'b0, rd_ptr_q} + (LW+1)'(1) == len_q;
    end

    always_ff @(posedge mem_clk) begin
        state_q <= rst ? state_d : IDLE;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = acc ? COLLECT : IDLE;
            COLLECT: state_d = flush ? REQ : COLLECT;
            REQ:     state_d = to_xfer ? XFER : REQ;
            XFER:    state_d = last ? IDLE : XFER;
        endcase
    end

    always_comb begin
        in_idle      = state_q == IDLE || state_q == COLLECT;
        ack_d        = acc;
        count_d      = last ? '0 : count_acc;
        next_addr_d  = addr_acc;
        start_addr_d = state_q == IDLE && acc ? in_wr_addr : start_addr_q;
        tmo_d        = state_q == COLLECT && !acc ? tmo_q + TW'(1) : '0;
        req_d        = flush ? 1'b1 : to_xfer ? 1'b0 : req_q;
        sd_addr_d    = flush ? start_addr_q : sd_addr_q;
        len_d        = flush ? count_acc : len_q;
        rd_ptr_d     = to_xfer ? '0 : step ? rd_ptr_q + LW'(1) : rd_ptr_q;
        data_d       = to_xfer ? buf_q[0] : step ? buf_q[rd_ptr_q + LW'(1)] : data_q;
    end

    always_ff @(posedge mem_clk) begin
        if (!rst) begin
            count_q      <= '0;
            next_addr_q  <= '0;
            start_addr_q <= '0;
            tmo_q        <= '0;
            rd_ptr_q     <= '0;
            ack_q        <= 1'b0;
            req_q        <= 1'b0;
            sd_addr_q    <= '0;
            len_q        <= '0;
            data_q       <= '0;
        end else begin
            count_q      <= count_d;
            next_addr_q  <= next_addr_d;
            start_addr_q <= start_addr_d;
            tmo_q        <= tmo_d;
            rd_ptr_q     <= rd_ptr_d;
            ack_q        <= ack_d;
            req_q        <= req_d;
            sd_addr_q    <= sd_addr_d;
            len_q        <= len_d;
            data_q       <= data_d;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (acc) buf_q[count_q[LW-1:0]] <= in_wr_data;
    end

    assign in_ack     = ack_q;
    assign sd_wr_req  = req_q;
    assign sd_wr_addr = sd_addr_q;
    assign sd_wr_len  = len_q;
    assign sd_wr_data = data_q;
endmodule

// File: tb/tb_mem_wr_burst.sv
// tb_mem_wr_burst: directed bench for mem_wr_burst with a recording controller-side monitor.
module tb_mem_wr_burst;
    localparam int AW = 25, DW = 16, BURST = 8, TIMEOUT = 16, COL_BITS = 9;

    logic          mem_clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_wr_req = 1'b0;
    logic [AW-1:0] in_wr_addr = '0;
    logic [DW-1:0] in_wr_data = '0;
    logic          in_ack, in_idle, sd_wr_req;
    logic [AW-1:0] sd_wr_addr;
    logic [3:0]    sd_wr_len;
    logic          sd_ack = 1'b1;
    logic          sd_data_next = 1'b1;
    logic [DW-1:0] sd_wr_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] cmd_a[$], cmd_l[$], data_w[$];
    int words_left = 0, ack_cnt = 0, dbl_cnt = 0;
    logic prev_ack = 1'b0;

    mem_wr_burst #(.AW(AW), .DW(DW), .BURST(BURST), .TIMEOUT(TIMEOUT), .COL_BITS(COL_BITS)) dut (
        .mem_clk(mem_clk), .rst(rst), .in_wr_req(in_wr_req), .in_wr_addr(in_wr_addr),
        .in_wr_data(in_wr_data), .in_ack(in_ack), .in_idle(in_idle), .sd_wr_req(sd_wr_req),
        .sd_wr_addr(sd_wr_addr), .sd_wr_len(sd_wr_len), .sd_ack(sd_ack),
        .sd_data_next(sd_data_next), .sd_wr_data(sd_wr_data)
    );

    always #5 mem_clk = ~mem_clk;

    // Records commands, consumed words and ack pulses just after each falling edge
    always begin
        @(negedge mem_clk);
        #1;
        if (!rst) begin
            words_left = 0;
            prev_ack = 1'b0;
        end else begin
            if (words_left > 0 && sd_data_next) begin
                data_w.push_back(32'(sd_wr_data));
                words_left--;
            end
            if (sd_wr_req && sd_ack) begin
                cmd_a.push_back(32'(sd_wr_addr));
                cmd_l.push_back(32'(sd_wr_len));
                words_left = int'(sd_wr_len);
            end
            if (in_ack) ack_cnt++;
            if (in_ack && prev_ack) dbl_cnt++;
            prev_ack = in_ack;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int a, input int d);
        int n;
        in_wr_req = 1'b1;
        in_wr_addr = AW'(a);
        in_wr_data = DW'(d);
        n = 0;
        do begin
            @(negedge mem_clk);
            n++;
        end while (!in_ack && n < 200);
        chk($sformatf("ack_%0h", a), 32'(in_ack), 1);
        @(negedge mem_clk);
        in_wr_req = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input int a, input int l);
        for (int i = 0; i < 300 && cmd_a.size() == 0; i++) @(negedge mem_clk);
        chk({tag, "_cmd_seen"}, 32'(cmd_a.size() != 0), 1);
        if (cmd_a.size() != 0) begin
            chk({tag, "_cmd_addr"}, cmd_a.pop_front(), a);
            chk({tag, "_cmd_len"}, cmd_l.pop_front(), l);
        end
    endtask

    task automatic expect_data(input string tag, input int base, input int n);
        for (int i = 0; i < 300 && data_w.size() < n; i++) @(negedge mem_clk);
        chk({tag, "_data_cnt"}, 32'(data_w.size() >= n), 1);
        for (int i = 0; i < n; i++)
            if (data_w.size() != 0) chk($sformatf("%s_data%0d", tag, i), data_w.pop_front(), base + i);
    endtask

    initial begin
        int base, n;
        repeat (3) @(negedge mem_clk);
        chk("rst_in_ack", 32'(in_ack), 0);
        chk("rst_sd_wr_req", 32'(sd_wr_req), 0);
        chk("rst_sd_wr_addr", 32'(sd_wr_addr), 0);
        chk("rst_sd_wr_len", 32'(sd_wr_len), 0);
        chk("rst_sd_wr_data", 32'(sd_wr_data), 0);
        rst = 1'b1;
        @(negedge mem_clk);
        chk("rst_in_idle", 32'(in_idle), 1);

        base = ack_cnt;
        for (int i = 0; i < 8; i++) write_word('h010 + i, 'hA000 + i);
        expect_cmd("t1", 'h010, 8);
        expect_data("t1", 'hA000, 8);
        chk("t1_acks", ack_cnt - base, 8);

        base = ack_cnt;
        for (int i = 0; i < 3; i++) write_word('h100 + i, 'h1000 + i);
        write_word('h200, 'h2000);
        chk("t2_xfer_before_ack", data_w.size(), 3);
        expect_cmd("t2a", 'h100, 3);
        expect_data("t2a", 'h1000, 3);
        expect_cmd("t2b", 'h200, 1);
        expect_data("t2b", 'h2000, 1);
        chk("t2_acks", ack_cnt - base, 4);

        write_word('h040, 'h4000);
        write_word('h041, 'h4001);
        n = 0;
        while (!sd_wr_req && n < 100) begin
            @(negedge mem_clk);
            n++;
        end
        chk("t3_timeout_latency", n, TIMEOUT - 1);
        expect_cmd("t3", 'h040, 2);
        expect_data("t3", 'h4000, 2);

        for (int i = 0; i < 3; i++) write_word('h1FE + i, 'h5000 + i);
        expect_cmd("t4a", 'h1FE, 2);
        expect_data("t4a", 'h5000, 2);
        expect_cmd("t4b", 'h200, 1);
        expect_data("t4b", 'h5002, 1);

        base = ack_cnt;
        sd_ack = 1'b0;
        sd_data_next = 1'b0;
        for (int i = 0; i < 8; i++) write_word('h300 + i, 'hB000 + i);
        in_wr_req = 1'b1;
        in_wr_addr = AW'('h308);
        in_wr_data = DW'('hB008);
        for (int i = 0; i < 20; i++) begin
            chk("t5_in_idle", 32'(in_idle), 0);
            chk("t5_in_ack", 32'(in_ack), 0);
            chk("t5_req", 32'(sd_wr_req), 1);
            chk("t5_addr", 32'(sd_wr_addr), 'h300);
            chk("t5_len", 32'(sd_wr_len), 8);
            @(negedge mem_clk);
        end
        sd_ack = 1'b1;
        @(negedge mem_clk);
        sd_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (2) begin
                chk($sformatf("t5_hold%0d", i), 32'(sd_wr_data), 'hB000 + i);
                @(negedge mem_clk);
            end
            sd_data_next = 1'b1;
            @(negedge mem_clk);
            sd_data_next = 1'b0;
        end
        n = 0;
        while (!in_ack && n < 50) begin
            @(negedge mem_clk);
            n++;
        end
        chk("t5_pending_ack", 32'(in_ack), 1);
        @(negedge mem_clk);
        in_wr_req = 1'b0;
        sd_ack = 1'b1;
        sd_data_next = 1'b1;
        expect_cmd("t5a", 'h300, 8);
        expect_data("t5a", 'hB000, 8);
        expect_cmd("t5b", 'h308, 1);
        expect_data("t5b", 'hB008, 1);
        chk("t5_acks", ack_cnt - base, 9);

        sd_data_next = 1'b0;
        for (int i = 0; i < 8; i++) write_word('h020 + i, 'hC000 + i);
        expect_cmd("t6", 'h020, 8);
        sd_data_next = 1'b1;
        repeat (3) @(negedge mem_clk);
        sd_data_next = 1'b0;
        rst = 1'b0;
        @(negedge mem_clk);
        chk("t6_req", 32'(sd_wr_req), 0);
        chk("t6_in_ack", 32'(in_ack), 0);
        chk("t6_data", 32'(sd_wr_data), 0);
        chk("t6_len", 32'(sd_wr_len), 0);
        rst = 1'b1;
        sd_data_next = 1'b1;
        @(negedge mem_clk);
        chk("t6_in_idle", 32'(in_idle), 1);
        repeat (40) @(negedge mem_clk);
        expect_data("t6", 'hC000, 3);
        chk("t6_no_cmd", cmd_a.size(), 0);
        chk("t6_no_data", data_w.size(), 0);
        chk("no_double_ack", dbl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end
endmodule
